// File: rtl/if_id_reg_if.sv
// if_id_reg_if
// Bundle of the fetch-side inputs, pipeline controls and decode-side outputs
// of the IF/ID pipeline register.
//   master : pipeline side (drives if_*, stall, flush; observes id_*)
//   slave  : the IF/ID register itself
// Signals:
//   if_instr[15:0], if_pc_next[15:0], if_valid : fetch results
//   stall, flush                               : hazard / control-transfer controls
//   id_instr[15:0], id_pc_next[15:0]           : registered values for decode
//   id_valid, id_halt                          : registered status for decode
//   stall_cnt[15:0]                            : only when IFID_STALL_CNT_EN is defined
interface if_id_reg_if;
  logic [15:0] if_instr;
  logic [15:0] if_pc_next;
  logic        if_valid;
  logic        stall;
  logic        flush;
  logic [15:0] id_instr;
  logic [15:0] id_pc_next;
  logic        id_valid;
  logic        id_halt;
`ifdef IFID_STALL_CNT_EN
  logic [15:0] stall_cnt;

  modport master (
    output if_instr, if_pc_next, if_valid, stall, flush,
    input  id_instr, id_pc_next, id_valid, id_halt, stall_cnt
  );

  modport slave (
    input  if_instr, if_pc_next, if_valid, stall, flush,
    output id_instr, id_pc_next, id_valid, id_halt, stall_cnt
  );
`else
  modport master (
    output if_instr, if_pc_next, if_valid, stall, flush,
    input  id_instr, id_pc_next, id_valid, id_halt
  );

  modport slave (
    input  if_instr, if_pc_next, if_valid, stall, flush,
    output id_instr, id_pc_next, id_valid, id_halt
  );
`endif
endinterface

// File: rtl/if_id_reg.sv
// if_id_reg
// IF/ID pipeline register of the 16-bit pipelined processor. Captures the
// fetched instruction and next sequential PC each rising edge and presents
// them to decode for a full cycle. Per-edge priority:
//   flush > halt-freeze > stall > load
// Bubbles are always the canonical NOP 16'h0800 so decode never sees a stale
// instruction. A valid HALT (opcode 5'b00000) freezes the stage until flushed.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : if_id_reg_if.slave (if_*, stall, flush in; id_* out)
// Optional feature macro: IFID_STALL_CNT_EN adds bus.stall_cnt, a saturating
// count of stall edges taken while a valid, non-halted instruction is held.
module if_id_reg (
  input  logic          clk,
  input  logic          rst,
  if_id_reg_if.slave    bus
);

  localparam logic [15:0] NOP_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    ACT_LOAD,
    ACT_HOLD,
    ACT_FREEZE,
    ACT_FLUSH
  } act_e;

  logic [15:0] instr_q;
  logic [15:0] pc_next_q;
  logic        valid_q;
  logic        halt_q;

  logic [15:0] instr_d;
  logic [15:0] pc_next_d;
  logic        valid_d;
  logic        halt_d;
  logic        in_is_halt;
  act_e        act;

  // HALT is only recognised on a real instruction; an invalid slot with a
  // zero opcode must never freeze the stage.
  assign in_is_halt = bus.if_valid && (bus.if_instr[15:11] == 5'b00000);

  always_comb begin
    if (bus.flush)      act = ACT_FLUSH;
    else if (halt_q)    act = ACT_FREEZE;
    else if (bus.stall) act = ACT_HOLD;
    else                act = ACT_LOAD;
  end

  always_comb begin
    instr_d   = instr_q;
    pc_next_d = pc_next_q;
    valid_d   = valid_q;
    halt_d    = halt_q;
    unique case (act)
      ACT_FLUSH: begin
        // PC is kept: only the instruction is squashed.
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        halt_d  = 1'b0;
      end
      ACT_LOAD: begin
        instr_d   = bus.if_valid ? bus.if_instr : NOP_INSTR;
        pc_next_d = bus.if_pc_next;
        valid_d   = bus.if_valid;
        halt_d    = in_is_halt;
      end
      ACT_FREEZE, ACT_HOLD: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q   <= NOP_INSTR;
      pc_next_q <= '0;
      valid_q   <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pc_next_q <= pc_next_d;
      valid_q   <= valid_d;
      halt_q    <= halt_d;
    end
  end

  assign bus.id_instr   = instr_q;
  assign bus.id_pc_next = pc_next_q;
  assign bus.id_valid   = valid_q;
  assign bus.id_halt    = halt_q;

`ifdef IFID_STALL_CNT_EN
  logic [15:0] stall_cnt_q;
  logic        cnt_inc;

  // Counts only genuine hazard stalls of a real instruction; a frozen HALT
  // stage or a flushed edge does not count.
  assign cnt_inc = bus.stall && !bus.flush && !halt_q && valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (cnt_inc && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// tb_if_id_reg
// Directed, table-driven bench for if_id_reg: a table of per-edge inputs with
// hand-computed expected outputs, plus hand-written sequences for reset
// behaviour and (with IFID_STALL_CNT_EN) counter saturation.
module tb_if_id_reg;

  logic clk;
  logic rst;
  int unsigned errors;
  int unsigned checks;

  if_id_reg_if bus ();

  if_id_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        valid;
    logic        stall;
    logic        flush;
    logic [15:0] e_instr;
    logic [15:0] e_pc;
    logic        e_valid;
    logic        e_halt;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name,
                              input logic [15:0] instr, input logic [15:0] pc,
                              input logic valid, input logic stall, input logic flush,
                              input logic [15:0] e_instr, input logic [15:0] e_pc,
                              input logic e_valid, input logic e_halt,
                              input logic [15:0] e_cnt);
    vec_t v;
    v.name = name; v.instr = instr; v.pc = pc; v.valid = valid;
    v.stall = stall; v.flush = flush; v.e_instr = e_instr; v.e_pc = e_pc;
    v.e_valid = e_valid; v.e_halt = e_halt; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [15:0] e_instr,
                         input logic [15:0] e_pc, input logic e_valid,
                         input logic e_halt, input logic [15:0] e_cnt);
    chk({name, ".instr"}, bus.id_instr, e_instr);
    chk({name, ".pc"}, bus.id_pc_next, e_pc);
    chk({name, ".valid"}, {15'd0, bus.id_valid}, {15'd0, e_valid});
    chk({name, ".halt"}, {15'd0, bus.id_halt}, {15'd0, e_halt});
`ifdef IFID_STALL_CNT_EN
    chk({name, ".cnt"}, bus.stall_cnt, e_cnt);
`else
    if (e_cnt === 16'hxxxx) $display("unused count expectation");
`endif
  endtask

  task automatic drive(input logic [15:0] instr, input logic [15:0] pc,
                       input logic valid, input logic stall, input logic flush);
    bus.if_instr   = instr;
    bus.if_pc_next = pc;
    bus.if_valid   = valid;
    bus.stall      = stall;
    bus.flush      = flush;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    drive(16'h0800, 16'h0000, 1'b0, 1'b0, 1'b0);

    //   name          instr    pc       v  s  f  e_instr  e_pc     ev eh cnt
    add("load_c123",   16'hC123, 16'h0001, 1, 0, 0, 16'hC123, 16'h0001, 1, 0, 16'd0);
    add("load_4a05",   16'h4A05, 16'h0003, 1, 0, 0, 16'h4A05, 16'h0003, 1, 0, 16'd0);
    add("stall1",      16'h1111, 16'h0005, 1, 1, 0, 16'h4A05, 16'h0003, 1, 0, 16'd1);
    add("stall2",      16'h1111, 16'h0005, 1, 1, 0, 16'h4A05, 16'h0003, 1, 0, 16'd2);
    add("stall3",      16'h1111, 16'h0005, 1, 1, 0, 16'h4A05, 16'h0003, 1, 0, 16'd3);
    add("load_6204",   16'h6204, 16'h0007, 1, 0, 0, 16'h6204, 16'h0007, 1, 0, 16'd3);
    add("flush_stall", 16'h7777, 16'h0009, 1, 1, 1, 16'h0800, 16'h0007, 0, 0, 16'd3);
    add("bubble",      16'h0000, 16'h000B, 0, 0, 0, 16'h0800, 16'h000B, 0, 0, 16'd3);
    add("load_halt",   16'h0000, 16'h000D, 1, 0, 0, 16'h0000, 16'h000D, 1, 1, 16'd3);
    add("frz_load",    16'h1234, 16'h000F, 1, 0, 0, 16'h0000, 16'h000D, 1, 1, 16'd3);
    add("frz_stall",   16'h2345, 16'h0011, 1, 1, 0, 16'h0000, 16'h000D, 1, 1, 16'd3);
    add("frz_inval",   16'h3456, 16'h0013, 0, 0, 0, 16'h0000, 16'h000D, 1, 1, 16'd3);
    add("halt_flush",  16'h4567, 16'h0015, 1, 0, 1, 16'h0800, 16'h000D, 0, 0, 16'd3);
    add("load_nop1",   16'h0801, 16'h0011, 1, 0, 0, 16'h0801, 16'h0011, 1, 0, 16'd3);
    add("load_07ff",   16'h07FF, 16'h0013, 1, 0, 0, 16'h07FF, 16'h0013, 1, 1, 16'd3);
    add("flush_halt2", 16'h5555, 16'h0015, 1, 1, 1, 16'h0800, 16'h0013, 0, 0, 16'd3);
    add("stall_inval", 16'h5555, 16'h0017, 1, 1, 0, 16'h0800, 16'h0013, 0, 0, 16'd3);
    add("load_ffff",   16'hFFFF, 16'hFFFE, 1, 0, 0, 16'hFFFF, 16'hFFFE, 1, 0, 16'd3);
    add("stall4",      16'h0000, 16'h0000, 1, 1, 0, 16'hFFFF, 16'hFFFE, 1, 0, 16'd4);

    #1;
    chk_all("reset", 16'h0800, 16'h0000, 1'b0, 1'b0, 16'd0);
    #12 rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].instr, vecs[i].pc, vecs[i].valid, vecs[i].stall, vecs[i].flush);
      @(posedge clk);
      #1;
      chk_all(vecs[i].name, vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_valid,
              vecs[i].e_halt, vecs[i].e_cnt);
    end

    // Asynchronous reset between edges must take effect immediately.
    @(negedge clk);
    drive(16'hC123, 16'h0021, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("pre_rst", 16'hC123, 16'h0021, 1'b1, 1'b0, 16'd4);
    #1 rst = 1'b1;
    #1;
    chk_all("async_rst", 16'h0800, 16'h0000, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(16'h4A05, 16'h0003, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("post_rst_load", 16'h4A05, 16'h0003, 1'b1, 1'b0, 16'd0);

`ifdef IFID_STALL_CNT_EN
    @(negedge clk);
    drive(16'h9999, 16'h0099, 1'b1, 1'b1, 1'b0);
    for (int unsigned n = 0; n < 65535; n++) @(posedge clk);
    #1;
    chk("sat_reach", bus.stall_cnt, 16'hFFFF);
    for (int unsigned n = 0; n < 5; n++) @(posedge clk);
    #1;
    chk_all("sat_hold", 16'h4A05, 16'h0003, 1'b1, 1'b0, 16'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
